mul_share_ctrl: RTL and testbench

Shared shift-add multiplier with request arbitration. Two requesters submit unsigned operand pairs. The block grants one requester, runs the multiply one bit per cycle, and presents the product with a single-cycle done pulse. It sits between client logic and the shift-add datapath. It owns both the sequencing FSM (INIT/EXEC/IDLE/HALT) and the selection of which requester uses the multiplier.

---
 rtl/mul_share_ctrl.sv | 129 ++++++++++++
 tb/tb_mul_share_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mul_share_ctrl.sv
// rtl/mul_share_ctrl.sv - shared shift-add multiplier with two-requester arbitration
// Optional round-robin arbitration enabled by defining MUL_SHARE_RR_EN (fixed priority otherwise).
module mul_share_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic [1:0]           req,
  input  logic [WIDTH-1:0]     a0,
  input  logic [WIDTH-1:0]     b0,
  input  logic [WIDTH-1:0]     a1,
  input  logic [WIDTH-1:0]     b1,
  output logic [1:0]           gnt,
  output logic                 busy,
  output logic [1:0]           state,
  output logic                 done,
  output logic                 done_id,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    INIT = 2'd0,
    EXEC = 2'd1,
    IDLE = 2'd2,
    HALT = 2'd3
  } state_t;

  state_t              cur, nxt;
  logic [2*WIDTH:0]    p, step_p;
  logic [WIDTH-1:0]    m;
  logic [CW-1:0]       cnt, cnt_inc;
  logic                owner, win;
  logic [WIDTH:0]      add_sum;
  logic [WIDTH-1:0]    sel_a, sel_b;

`ifdef MUL_SHARE_RR_EN
  logic ptr;
  // ptr only matters under contention; a lone requester always wins.
  always_comb win = (req == 2'b11) ? ptr : ~req[0];
`else
  always_comb win = ~req[0];
`endif

  always_comb begin
    sel_a = win ? a1 : a0;
    sel_b = win ? b1 : b0;
  end

  // Carry is always zero going into the add after a shift, so WIDTH+1 bits never overflow.
  always_comb add_sum = p[2*WIDTH:WIDTH] + {1'b0, m};

  always_comb begin
    step_p = {1'b0, p[2*WIDTH:1]};
    if (cur == EXEC) step_p = {1'b0, add_sum, p[WIDTH-1:1]};
  end

  always_comb cnt_inc = cnt + 1'b1;

  always_comb begin
    nxt = cur;
    gnt = 2'b00;
    case (cur)
      INIT: begin
        if (req != 2'b00) begin
          gnt = win ? 2'b10 : 2'b01;
          nxt = sel_b[0] ? EXEC : IDLE;
        end
      end
      EXEC, IDLE: begin
        if (cnt_inc == CW'(WIDTH)) nxt = HALT;
        else                       nxt = step_p[0] ? EXEC : IDLE;
      end
      HALT:    nxt = INIT;
      default: nxt = INIT;
    endcase
    if (areset) gnt = 2'b00;
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) cur <= INIT;
    else        cur <= nxt;
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      p       <= '0;
      m       <= '0;
      cnt     <= '0;
      owner   <= 1'b0;
      product <= '0;
      done_id <= 1'b0;
`ifdef MUL_SHARE_RR_EN
      ptr     <= 1'b0;
`endif
    end else begin
      case (cur)
        INIT: begin
          if (req != 2'b00) begin
            m     <= sel_a;
            p     <= {1'b0, {WIDTH{1'b0}}, sel_b};
            cnt   <= '0;
            owner <= win;
          end
        end
        EXEC, IDLE: begin
          p   <= step_p;
          cnt <= cnt_inc;
          if (nxt == HALT) begin
            product <= step_p[2*WIDTH-1:0];
            done_id <= owner;
          end
        end
        HALT: begin
`ifdef MUL_SHARE_RR_EN
          ptr <= ~owner;
`endif
        end
        default: ;
      endcase
    end
  end

  assign state = cur;
  assign busy  = (cur != INIT);
  assign done  = (cur == HALT);

endmodule

// File: tb/tb_mul_share_ctrl.sv
// tb/tb_mul_share_ctrl.sv - self-checking bench for mul_share_ctrl
// Expected results come from plain multiplication and the operand bit pattern.
module tb_mul_share_ctrl;

  localparam int W = 8;

  logic          clk = 1'b0;
  logic          areset;
  logic [1:0]    req;
  logic [W-1:0]  a0, b0, a1, b1;
  logic [1:0]    gnt;
  logic          busy;
  logic [1:0]    state;
  logic          done;
  logic          done_id;
  logic [2*W-1:0] product;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_grant_cyc = 0;

  mul_share_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .areset(areset), .req(req),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt(gnt), .busy(busy), .state(state), .done(done),
    .done_id(done_id), .product(product)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Waits for a grant, then follows one complete operation to its done cycle.
  task automatic run_op(input int exp_id, input logic [W-1:0] ea, input logic [W-1:0] eb,
                        input bit drop_req);
    int n;
    int exp_prod;
    n = 0;
    #1;
    while (gnt == 2'b00 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("grant_seen", {31'd0, gnt != 2'b00}, 32'd1);
    if (gnt == 2'b00) return;
    check("gnt", {30'd0, gnt}, (exp_id == 1) ? 32'd2 : 32'd1);
    last_grant_cyc = cyc;
    exp_prod = int'(ea) * int'(eb);
    @(posedge clk);
    #1;
    if (drop_req) req = 2'b00;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      check($sformatf("step%0d_state", i), {30'd0, state}, eb[i] ? 32'd1 : 32'd2);
      check("step_busy", {31'd0, busy}, 32'd1);
      check("step_done", {31'd0, done}, 32'd0);
      check("step_gnt", {30'd0, gnt}, 32'd0);
    end
    @(negedge clk);
    check("halt_state", {30'd0, state}, 32'd3);
    check("halt_done", {31'd0, done}, 32'd1);
    check("product", {16'd0, product}, exp_prod);
    check("done_id", {31'd0, done_id}, exp_id);
    @(negedge clk);
    check("post_state", {30'd0, state}, 32'd0);
    check("post_done", {31'd0, done}, 32'd0);
    check("product_held", {16'd0, product}, exp_prod);
  endtask

  initial begin
    int id;
    int w;
    int ptr_m;
    int prev_g;
    logic [W-1:0] ra, rb;

    areset = 1'b1;
    req = 2'b11;
    a0 = 8'd5; b0 = 8'd3; a1 = 8'd6; b1 = 8'd7;
    @(negedge clk);
    @(negedge clk);
    check("rst_gnt", {30'd0, gnt}, 32'd0);
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_product", {16'd0, product}, 32'd0);
    check("rst_done_id", {31'd0, done_id}, 32'd0);

    areset = 1'b0;
    req = 2'b01; a0 = 8'd13; b0 = 8'd11;
    run_op(0, 8'd13, 8'd11, 1'b1);

    req = 2'b01; a0 = 8'd255; b0 = 8'd255;
    run_op(0, 8'd255, 8'd255, 1'b1);
    req = 2'b01; a0 = 8'd0; b0 = 8'd255;
    run_op(0, 8'd0, 8'd255, 1'b1);
    req = 2'b10; a1 = 8'd200; b1 = 8'd0;
    run_op(1, 8'd200, 8'd0, 1'b1);

    for (int k = 0; k < 8; k++) begin
      id = int'($urandom_range(0, 1));
      ra = W'($urandom);
      rb = W'($urandom);
      a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
      if (id == 1) begin a1 = ra; b1 = rb; req = 2'b10; end
      else         begin a0 = ra; b0 = rb; req = 2'b01; end
      run_op(id, ra, rb, 1'b1);
    end

    // Abandon an operation with reset during its 4th step cycle.
    req = 2'b01; a0 = W'($urandom); b0 = W'($urandom);
    #1;
    check("mid_grant", {30'd0, gnt}, 32'd1);
    @(posedge clk);
    #1;
    req = 2'b00;
    repeat (4) @(negedge clk);
    check("mid_busy_before", {31'd0, busy}, 32'd1);
    areset = 1'b1;
    #1;
    check("mid_state", {30'd0, state}, 32'd0);
    check("mid_busy", {31'd0, busy}, 32'd0);
    check("mid_product", {16'd0, product}, 32'd0);
    req = 2'b11;
    #1;
    check("mid_gnt_forced", {30'd0, gnt}, 32'd0);
    req = 2'b00;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("mid_no_done", {31'd0, done}, 32'd0);
    end
    areset = 1'b0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      check("mid_idle_done", {31'd0, done}, 32'd0);
    end
    check("mid_idle_state", {30'd0, state}, 32'd0);
    req = 2'b10; a1 = 8'd7; b1 = 8'd9;
    run_op(1, 8'd7, 8'd9, 1'b1);

    // Contention: ptr is back to 0 after requester 1 finished.
    areset = 1'b1;
    @(negedge clk);
    areset = 1'b0;
    a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
    req = 2'b11;
    ptr_m = 0;
    prev_g = 0;
    for (int k = 0; k < 3; k++) begin
`ifdef MUL_SHARE_RR_EN
      w = ptr_m;
`else
      w = 0;
`endif
      run_op(w, (w == 1) ? a1 : a0, (w == 1) ? b1 : b0, 1'b0);
      if (k > 0) check("grant_spacing", last_grant_cyc - prev_g, W + 2);
      prev_g = last_grant_cyc;
      ptr_m = w ^ 1;
    end
    req = 2'b00;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
